div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit radix-2 divider for the MIPS execute stage, serving DIV/DIVU. It consumes the operands of a divide instruction in E and produces HI (remainder) and LO (quotient). It drives `div_running` to the hazard unit, which stalls F/D/E while the divide is in progress. One quotient bit is resolved per cycle, with early completion on divide-by-zero.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported by the pipeline.

Ports:
- `clk`, input, 1: pipeline clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: a DIV/DIVU is in E. Held high by the pipeline while E is stalled.
- `signed_div`, input, 1: 1 = DIV (two's complement), 0 = DIVU. Sampled on acceptance.
- `annul`, input, 1: flush or exception. Aborts any operation in progress.
- `opdata1`, input, 32: dividend (rs value). Sampled on acceptance.
- `opdata2`, input, 32: divisor (rt value). Sampled on acceptance.
- `result`, output, 64: {HI = remainder, LO = quotient}. Registered.
- `ready`, output, 1: one-cycle pulse; `result` is valid in that cycle.
- `div_running`, output, 1: stall request to the hazard unit.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: `result` = 0, `ready` = 0. `div_running` = 0 while `rst` is high.
- `div_running = start & ~annul & (state != DONE)`. It is combinational so the hazard unit stalls in the same cycle the instruction enters E.
- IDLE:
  - When `start & ~annul`, accept the operation: latch `signed_div` and the operands.
  - If `opdata2 == 0`, go to DONE.
  - Otherwise, go to BUSY with a 6-bit counter = 0.
  - For signed operations, latch absolute values of both operands, plus quotient sign = sign1 XOR sign2 and remainder sign = sign1.
- BUSY: performs restoring division.
  - Each cycle, shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise set it to 0.
  - The counter increments each cycle. After the 32nd iteration (counter == 31), go to DONE.
- DONE:
  - Register `result` and pulse `ready` = 1. The cycle after, return to IDLE.
  - Signed operations apply the latched signs: negate the quotient if the quotient sign is 1, and negate the remainder if the remainder sign is 1.
- Divide-by-zero (decided behaviour): LO = 32'hFFFF_FFFF, HI = dividend as supplied (unmodified). This applies to both DIV and DIVU.
- Overflow: 0x8000_0000 / 0xFFFF_FFFF (signed) yields LO = 0x8000_0000, HI = 0, i.e. natural wrap with no trap.
- `annul` in any state:
  - Next state is IDLE.
  - `ready` is not asserted, and `result` keeps its previous value.
  - `annul` has priority over `start` and over completion.
- `start` deasserting while in BUSY (instruction squashed without `annul`) is treated as an abort: go to IDLE, no `ready`.
- `result` holds its value between completions. It changes only in a DONE cycle.
- Asynchronous reset asserted mid-operation: return to IDLE immediately, clear `result` and `ready`, and discard the partial state.

## Timing
- Normal divide: the operation is accepted at cycle 0 (IDLE, `start` high).
  - BUSY occupies cycles 1–32.
  - DONE is cycle 33: `ready` = 1, `result` valid, `div_running` = 0, so E advances at the end of cycle 33.
  - `div_running` is high for exactly 33 cycles (0–32).
- Divide-by-zero: accepted at cycle 0, DONE at cycle 1. `div_running` is high for 1 cycle.
- Back-to-back divides: a second DIV entering E in cycle 34 (state IDLE) is accepted normally. There is no dead cycle beyond the DONE→IDLE return.
- `ready` is never high for more than one consecutive cycle.

## Test plan
- DIVU 100 / 7 with `start` held: `div_running` high in cycles 0–32; `ready` in cycle 33; `result` = {HI 2, LO 14}; `ready` low in cycle 34.
- DIV −7 / 2 (0xFFFF_FFF9 / 2): LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIV 7 / −2 gives LO = 0xFFFF_FFFD, HI = 1.
- DIVU 0x1234 / 0: `ready` in cycle 1, `div_running` high only in cycle 0, LO = 0xFFFF_FFFF, HI = 0x1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0, `ready` in cycle 33.
- `annul` pulsed in cycle 10 of a DIVU 50 / 5: no `ready`; `div_running` low from cycle 10; `result` unchanged. A new DIVU 9 / 3 started in cycle 12 completes in cycle 45 with LO = 3, HI = 0.
- `rst` asserted mid-cycle during BUSY (cycle 20): outputs go to 0 immediately, without waiting for a clock edge. After release, DIVU 0xFFFF_FFFF / 1 yields LO = 0xFFFF_FFFF, HI = 0 in 33 cycles.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Ports: clk, rst (async high), start, signed_div, annul, opdata1/opdata2 in;
//   result {HI=rem, LO=quot}, ready (1-cycle pulse), div_running (stall) out.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               div_running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // dvd shifts out dividend bits on the left and collects
  // quotient bits on the right.
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic [5:0]         cnt;
  logic               neg_q;
  logic               neg_r;

  // staged is the freshly computed answer, visible only during
  // a non-annulled DONE cycle; held is the last committed one.
  logic [2*WIDTH-1:0] staged;
  logic [2*WIDTH-1:0] held;

  logic               go;
  logic               zero;
  logic               last;
  logic               step;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   q_nx;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;

  assign go   = start & ~annul;
  assign zero = (opdata2 == '0);
  assign last = (cnt == 6'(WIDTH - 1));
  assign step = start & ~annul;

  assign abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // The shifted partial remainder is always below 2*divisor, so a
  // 2-bit headroom subtract gives a clean sign bit.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign qbit    = ~diff[WIDTH+1];
  assign rem_nx  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_nx    = {dvd[WIDTH-2:0], qbit};

  // 0x8000_0000 / -1 wraps naturally here: |q| = 2^31 negated
  // by neither sign, so LO stays 0x8000_0000.
  assign q_fin = neg_q ? -q_nx : q_nx;
  assign r_fin = neg_r ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ready       = 1'b0;
    div_running = 1'b0;
    result      = held;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nx = zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!start) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        ready    = 1'b1;
        result   = staged;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (annul) begin
      state_nx = IDLE;
      ready    = 1'b0;
      result   = held;
    end
    div_running = start & ~annul & ~rst & (state != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      staged <= '0;
      held   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            dvs   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r <= signed_div & opdata1[WIDTH-1];
            dvd   <= abs1;
            // Divide-by-zero skips the iteration entirely; the raw
            // dividend goes straight to HI.
            if (zero) begin
              staged <= {opdata1, {WIDTH{1'b1}}};
            end
          end
        end
        BUSY: begin
          if (step) begin
            rem <= rem_nx;
            dvd <= q_nx;
            cnt <= cnt + 6'd1;
            if (last) begin
              staged <= {r_fin, q_fin};
            end
          end
        end
        DONE: begin
          if (!annul) begin
            held <= staged;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard queue of expected
// {HI,LO} values, popped and compared whenever ready pulses.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        div_running;

  int checks;
  int failures;

  logic [63:0] exp_q[$];
  logic [63:0] last_result;

  div_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_div(signed_div),
    .annul(annul),
    .opdata1(opdata1),
    .opdata2(opdata2),
    .result(result),
    .ready(ready),
    .div_running(div_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model_div(input logic sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives one divide with start held until ready, then drops start.
  // Cycle 0 is the acceptance cycle; rdy_cyc is -1 on timeout.
  task automatic do_div(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output int rdy_cyc,
                        output int run_cnt, output logic [63:0] res,
                        output logic rdy_after);
    rdy_cyc   = -1;
    run_cnt   = 0;
    res       = '0;
    rdy_after = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (div_running) run_cnt++;
      if (ready) begin
        rdy_cyc = c;
        res     = result;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b1;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = 32'd10;
    opdata2    = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_running !== 1'b0) begin
      failures++;
      $display("FAIL reset_running: got %b want 0", div_running);
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b want 0", ready);
    end
    checks++;
    if (result !== 64'd0) begin
      failures++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    start = 1'b0;
    rst   = 1'b0;
    last_result = 64'd0;
  endtask

  task automatic test_divu_basic();
    int rc;
    int rn;
    logic [63:0] r;
    logic ra;
    logic [63:0] e;
    exp_q.push_back({32'd2, 32'd14});
    do_div(1'b0, 32'd100, 32'd7, rc, rn, r, ra);
    checks++;
    if (rc !== 33) begin
      failures++;
      $display("FAIL divu_ready_cycle: got %0d want 33", rc);
    end
    checks++;
    if (rn !== 33) begin
      failures++;
      $display("FAIL divu_running_cycles: got %0d want 33", rn);
    end
    checks++;
    if (ra !== 1'b0) begin
      failures++;
      $display("FAIL divu_ready_after: got %b want 0", ra);
    end
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL divu_result: got %h want %h", r, e);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== e) begin
      failures++;
      $display("FAIL divu_result_hold: got %h want %h", result, e);
    end
    last_result = e;
  endtask

  task automatic test_signed();
    logic [31:0] av[2];
    logic [31:0] bv[2];
    logic [63:0] ev[2];
    int rc;
    int rn;
    logic [63:0] r;
    logic ra;
    logic [63:0] e;
    av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;
    ev[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    av[1] = 32'd7;         bv[1] = 32'hFFFF_FFFE;
    ev[1] = {32'd1, 32'hFFFF_FFFD};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ev[i]);
      do_div(1'b1, av[i], bv[i], rc, rn, r, ra);
      e = exp_q.pop_front();
      checks++;
      if (rc !== 33) begin
        failures++;
        $display("FAIL signed_ready_cycle[%0d]: got %0d want 33", i, rc);
      end
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL signed_result[%0d]: got %h want %h", i, r, e);
      end
      last_result = e;
    end
  endtask

  task automatic test_div_by_zero();
    int rc;
    int rn;
    logic [63:0] r;
    logic ra;
    logic [63:0] e;
    exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    do_div(1'b0, 32'h1234, 32'd0, rc, rn, r, ra);
    e = exp_q.pop_front();
    checks++;
    if (rc !== 1) begin
      failures++;
      $display("FAIL dbz_ready_cycle: got %0d want 1", rc);
    end
    checks++;
    if (rn !== 1) begin
      failures++;
      $display("FAIL dbz_running_cycles: got %0d want 1", rn);
    end
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL dbz_result: got %h want %h", r, e);
    end
    exp_q.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, rc, rn, r, ra);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || rc !== 1) begin
      failures++;
      $display("FAIL dbz_signed: got %h@%0d want %h@1", r, rc, e);
    end
    last_result = e;
  endtask

  task automatic test_overflow();
    int rc;
    int rn;
    logic [63:0] r;
    logic ra;
    logic [63:0] e;
    exp_q.push_back({32'd0, 32'h8000_0000});
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rc, rn, r, ra);
    e = exp_q.pop_front();
    checks++;
    if (rc !== 33) begin
      failures++;
      $display("FAIL ovf_ready_cycle: got %0d want 33", rc);
    end
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL ovf_result: got %h want %h", r, e);
    end
    last_result = e;
  endtask

  task automatic test_annul();
    logic saw_ready;
    int rc;
    logic [63:0] e;
    saw_ready = 1'b0;
    rc = -1;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd5;
    for (int c = 0; c < 12; c++) begin
      if (c == 10) annul = 1'b1;
      if (c == 11) begin
        annul = 1'b0;
        start = 1'b0;
      end
      #1;
      if (ready) saw_ready = 1'b1;
      if (c >= 10) begin
        checks++;
        if (div_running !== 1'b0) begin
          failures++;
          $display("FAIL annul_running[c%0d]: got %b want 0", c, div_running);
        end
      end
      if (c == 11) begin
        checks++;
        if (result !== last_result) begin
          failures++;
          $display("FAIL annul_result_kept: got %h want %h", result, last_result);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      failures++;
      $display("FAIL annul_no_ready: got %b want 0", saw_ready);
    end
    exp_q.push_back({32'd0, 32'd3});
    start   = 1'b1;
    opdata1 = 32'd9;
    opdata2 = 32'd3;
    for (int c = 12; c < 60; c++) begin
      #1;
      if (ready) begin
        rc = c;
        break;
      end
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    checks++;
    if (rc !== 45) begin
      failures++;
      $display("FAIL annul_restart_cycle: got %0d want 45", rc);
    end
    checks++;
    if (result !== e) begin
      failures++;
      $display("FAIL annul_restart_result: got %h want %h", result, e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    last_result = e;
  endtask

  task automatic test_rst_mid();
    int rc;
    int rn;
    logic [63:0] r;
    logic ra;
    logic [63:0] e;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (div_running !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl: got run=%b rdy=%b want 0/0", div_running, ready);
    end
    checks++;
    if (result !== 64'd0) begin
      failures++;
      $display("FAIL rst_mid_result: got %h want 0", result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    exp_q.push_back({32'd0, 32'hFFFF_FFFF});
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, rc, rn, r, ra);
    e = exp_q.pop_front();
    checks++;
    if (rc !== 33) begin
      failures++;
      $display("FAIL rst_after_cycle: got %0d want 33", rc);
    end
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL rst_after_result: got %h want %h", r, e);
    end
    last_result = e;
  endtask

  task automatic test_back_to_back();
    int rcs[$];
    logic prev_rdy;
    logic [63:0] e;
    prev_rdy = 1'b0;
    exp_q.push_back(model_div(1'b0, 32'd1000, 32'd33));
    exp_q.push_back(model_div(1'b1, 32'hFFFF_FC18, 32'd7));
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd33;
    for (int c = 0; c < 80; c++) begin
      if (rcs.size() == 1 && c == rcs[0] + 1) begin
        signed_div = 1'b1;
        opdata1    = 32'hFFFF_FC18;
        opdata2    = 32'd7;
      end
      if (rcs.size() == 2) start = 1'b0;
      #1;
      if (ready) begin
        checks++;
        if (prev_rdy) begin
          failures++;
          $display("FAIL b2b_ready_width: got 2 cycles want 1");
        end
        rcs.push_back(c);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (result !== e) begin
            failures++;
            $display("FAIL b2b_result[%0d]: got %h want %h", rcs.size(), result, e);
          end
          last_result = e;
        end
      end
      prev_rdy = ready;
      if (rcs.size() == 2 && !ready) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (rcs.size() !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 2", rcs.size());
    end else begin
      checks++;
      if (rcs[0] !== 33 || rcs[1] !== 67) begin
        failures++;
        $display("FAIL b2b_cycles: got %0d,%0d want 33,67", rcs[0], rcs[1]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int rc;
    int rn;
    logic [63:0] r;
    logic ra;
    logic [63:0] e;
    logic sgn;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) b = 32'd0;
      exp_q.push_back(model_div(sgn, a, b));
      do_div(sgn, a, b, rc, rn, r, ra);
      e = exp_q.pop_front();
      checks++;
      if (r !== e || rc !== ((b == 32'd0) ? 1 : 33)) begin
        failures++;
        $display("FAIL rand[%0d] s=%b %h/%h: got %h@%0d want %h", i, sgn, a, b, r, rc, e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_annul();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
